lcd_sequencer: RTL
==================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 clk  input  1  system clock, 50 MHz (20 ns period); all timing below is in clk cycles.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 init_sel  output  1  1 = this block drives the LCD pins directly (power-on nibble phase); 0 = command unit drives them.
REQ-004 init_sf_d  output  4  nibble placed on SF_D during the power-on phase.
REQ-005 init_lcd_e  output  1  LCD_E during the power-on phase.
REQ-006 cmd_ready  output  1  one-cycle start pulse to the command unit.
REQ-007 cmd_db  output  8  byte for the command unit.
REQ-008 cmd_instr  output  4  instruction code for the command unit: 4'b1010 = data write (RS=1, RW=0); 4'b0000 = generic command (RS=0, RW=0).
REQ-009 cmd_done  input  1  one-cycle pulse from the command unit when its transfer and 40 us wait are complete.
REQ-010 char_addr  output  5  screen position 0-31; 0-15 is line 1, 16-31 is line 2.
REQ-011 char_data  input  8  ASCII code at char_addr; combinational, valid in the same cycle.
REQ-012 Parameters, with defaults:
- T_PWR = 750000 (15 ms)
- T_W1 = 205000 (4.1 ms)
- T_W2 = 5000 (100 us)
- T_W3 = 2000 (40 us)
- T_E = 12 (240 ns LCD_E high)
- T_CLR = 82000 (1.64 ms)
- T_FRAME = 50000 (1 ms between refreshes)

Function
REQ-013 There SHALL be one 20-bit wait counter, zeroed on every state entry; a wait of N SHALL complete on the cycle the counter equals N-1.
REQ-014 The states SHALL be PWR_WAIT, NIB_SETUP, NIB_PULSE, NIB_WAIT, CFG_ISSUE, CFG_WAIT, CLR_WAIT, ADDR_ISSUE, ADDR_WAIT, CHR_ISSUE, CHR_WAIT and FRAME_WAIT.
REQ-015 PWR_WAIT SHALL last T_PWR cycles, then go to NIB_SETUP with nib_idx = 0.
REQ-016 Power-on nibble phase:
- NIB_SETUP SHALL drive init_sf_d for 2 cycles: 3, 3, 3, 2 for nib_idx 0-3.
- NIB_PULSE SHALL hold init_lcd_e = 1 for T_E cycles.
- NIB_WAIT SHALL hold init_lcd_e = 0 for T_W1, T_W2, T_W3, T_W3 cycles for nib_idx 0-3.
- After nib_idx 3 the block SHALL go to CFG_ISSUE with cfg_idx = 0; otherwise it SHALL increment nib_idx and return to NIB_SETUP.
REQ-017 init_sel SHALL be 1 from reset until the exit from NIB_WAIT with nib_idx 3, and 0 thereafter; init_sf_d SHALL be 0 whenever init_sel = 0.
REQ-018 Configuration phase:
- CFG_ISSUE SHALL pulse cmd_ready for 1 cycle with cmd_instr = 0000 and cmd_db = 28h, 06h, 0Ch, 01h for cfg_idx 0-3.
- CFG_WAIT SHALL wait for cmd_done.
- After cfg_idx 3 (clear) the block SHALL go to CLR_WAIT for T_CLR cycles, then to ADDR_ISSUE with line = 0.
REQ-019 ADDR_ISSUE SHALL pulse cmd_ready with cmd_instr = 0000, cmd_db = 80h (line 0) or C0h (line 1), then wait in ADDR_WAIT for cmd_done.
REQ-020 Character write phase:
- CHR_ISSUE SHALL pulse cmd_ready with cmd_instr = 1010 and cmd_db = char_data sampled at char_addr = {line, col}; CHR_WAIT SHALL wait for cmd_done.
- After col 15 the block SHALL go to ADDR_ISSUE for line 1, or to FRAME_WAIT after line 1; otherwise it SHALL increment col and return to CHR_ISSUE.
REQ-021 FRAME_WAIT SHALL last T_FRAME cycles, then go to ADDR_ISSUE with line = 0 and col = 0, repeating forever.
REQ-022 cmd_db and cmd_instr SHALL be registered and held stable from the cmd_ready cycle until the cycle after cmd_done.
REQ-023 cmd_done SHALL be ignored in every state except CFG_WAIT, ADDR_WAIT and CHR_WAIT; cmd_done arriving on the same cycle as cmd_ready SHALL be ignored.
REQ-024 There SHALL be at most one outstanding command; cmd_ready SHALL never assert twice without an intervening cmd_done.
REQ-025 col SHALL wrap from 15 to 0 and line from 1 to 0; char_addr SHALL never exceed 31.

Reset
REQ-026 On reset assertion the block SHALL immediately enter PWR_WAIT with counter, nib_idx, cfg_idx, line and col at 0.
REQ-027 On reset assertion the outputs SHALL be init_sel = 1, init_sf_d = 0, init_lcd_e = 0, cmd_ready = 0, cmd_db = 00h, cmd_instr = 0000, char_addr = 0.
REQ-028 Reset asserted mid-operation, including mid-command, SHALL restart the full power-on sequence; the command unit is reset by the same signal.

Structure
REQ-029 The timing parameters, state encodings, instruction codes and the four configuration bytes SHALL live in a shared package, lcd_pkg.
REQ-030 A sub-module lcd_cfg_rom SHALL map cfg_idx to the configuration byte; the pin multiplexer selected by init_sel SHALL sit at top level, outside this block.

Verification
REQ-031 Run with reduced parameters T_PWR = 100, T_W1 = 50, T_W2 = 20, T_W3 = 10, T_CLR = 30, T_FRAME = 40, T_E = 12.
REQ-032 Bench scenarios:
- Release reset -> init_lcd_e pulses exactly 4 times, each 12 cycles high, with init_sf_d 3, 3, 3, 2; the first pulse rises at cycle 102.
- Model the command unit with cmd_done 5 cycles after each cmd_ready -> bytes 28h, 06h, 0Ch, 01h in order, then 30 idle cycles, then 80h.
- char_data = 41h + char_addr -> data writes 41h-50h after 80h and 51h-60h after C0h, then a 40-cycle gap, then 80h again.
- Spurious cmd_done pulses injected during CLR_WAIT and FRAME_WAIT -> no state change, no extra cmd_ready.
- Assert reset during a CHR_WAIT -> all outputs return to reset values immediately and init_sel = 1 until the nibble phase completes again.
- Command unit stalls for 1000 cycles -> cmd_db and cmd_instr stay stable throughout and no second cmd_ready is issued.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD power-on / refresh sequencer: default timings,
// state encoding, command-unit instruction codes and the fixed configuration bytes.
package lcd_pkg;

  localparam int CNT_W = 20;

  // Default timings in 50 MHz clock cycles
  localparam int T_PWR_DEF   = 750000;
  localparam int T_W1_DEF    = 205000;
  localparam int T_W2_DEF    = 5000;
  localparam int T_W3_DEF    = 2000;
  localparam int T_E_DEF     = 12;
  localparam int T_CLR_DEF   = 82000;
  localparam int T_FRAME_DEF = 50000;

  typedef enum logic [3:0] {
    PWR_WAIT   = 4'd0,
    NIB_SETUP  = 4'd1,
    NIB_PULSE  = 4'd2,
    NIB_WAIT   = 4'd3,
    CFG_ISSUE  = 4'd4,
    CFG_WAIT   = 4'd5,
    CLR_WAIT   = 4'd6,
    ADDR_ISSUE = 4'd7,
    ADDR_WAIT  = 4'd8,
    CHR_ISSUE  = 4'd9,
    CHR_WAIT   = 4'd10,
    FRAME_WAIT = 4'd11
  } lcd_state_t;

  localparam logic [3:0] INSTR_CMD  = 4'b0000;
  localparam logic [3:0] INSTR_DATA = 4'b1010;

  localparam logic [7:0] CFG_FUNC_SET   = 8'h28;
  localparam logic [7:0] CFG_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CFG_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] CFG_CLEAR      = 8'h01;

  localparam logic [7:0] DDRAM_LINE0 = 8'h80;
  localparam logic [7:0] DDRAM_LINE1 = 8'hC0;

  localparam logic [3:0] NIB_WAKE = 4'h3;
  localparam logic [3:0] NIB_4BIT = 4'h2;

  // Three wake-up nibbles, then the switch to 4-bit mode
  function automatic logic [3:0] nib_value(input logic [1:0] idx);
    return (idx == 2'd3) ? NIB_4BIT : NIB_WAKE;
  endfunction

  // A wait of n cycles ends on the cycle the counter reads n-1
  function automatic logic [CNT_W-1:0] wait_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/lcd_cfg_rom.sv
// Maps the configuration step index to the command byte sent during LCD setup.
module lcd_cfg_rom
  import lcd_pkg::*;
(
  input  logic [1:0] cfg_idx,
  output logic [7:0] cfg_byte
);

  always_comb begin
    cfg_byte = CFG_FUNC_SET;
    case (cfg_idx)
      2'd0:    cfg_byte = CFG_FUNC_SET;
      2'd1:    cfg_byte = CFG_ENTRY_MODE;
      2'd2:    cfg_byte = CFG_DISPLAY_ON;
      default: cfg_byte = CFG_CLEAR;
    endcase
  end

endmodule

// File: rtl/lcd_sequencer.sv
// Drives the LCD power-on nibble sequence directly, then configures the display and
// refreshes both 16-character lines forever through a one-command-at-a-time command unit.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int T_PWR   = T_PWR_DEF,
  parameter int T_W1    = T_W1_DEF,
  parameter int T_W2    = T_W2_DEF,
  parameter int T_W3    = T_W3_DEF,
  parameter int T_E     = T_E_DEF,
  parameter int T_CLR   = T_CLR_DEF,
  parameter int T_FRAME = T_FRAME_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       init_sel,
  output logic [3:0] init_sf_d,
  output logic       init_lcd_e,
  output logic       cmd_ready,
  output logic [7:0] cmd_db,
  output logic [3:0] cmd_instr,
  input  logic       cmd_done,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data
);

  localparam logic [CNT_W-1:0] L_PWR   = wait_last(T_PWR);
  localparam logic [CNT_W-1:0] L_W1    = wait_last(T_W1);
  localparam logic [CNT_W-1:0] L_W2    = wait_last(T_W2);
  localparam logic [CNT_W-1:0] L_W3    = wait_last(T_W3);
  localparam logic [CNT_W-1:0] L_E     = wait_last(T_E);
  localparam logic [CNT_W-1:0] L_CLR   = wait_last(T_CLR);
  localparam logic [CNT_W-1:0] L_FRAME = wait_last(T_FRAME);
  localparam logic [CNT_W-1:0] L_SETUP = wait_last(2);

  lcd_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_nib_idx;
  logic [1:0]       r_cfg_idx;
  logic             r_line;
  logic [3:0]       r_col;
  logic             r_init_sel;
  logic [3:0]       r_init_sf_d;
  logic             r_init_lcd_e;
  logic             r_cmd_ready;
  logic [7:0]       r_cmd_db;
  logic [3:0]       r_cmd_instr;

  logic [CNT_W-1:0] w_nib_last;
  logic [1:0]       w_rom_idx;
  logic [7:0]       w_cfg_byte;

  always_comb begin
    w_nib_last = L_W3;
    case (r_nib_idx)
      2'd0:    w_nib_last = L_W1;
      2'd1:    w_nib_last = L_W2;
      default: w_nib_last = L_W3;
    endcase
  end

  // While waiting on a config command, look up the byte for the step that follows it
  assign w_rom_idx = (r_state == CFG_WAIT) ? (r_cfg_idx + 2'd1) : r_cfg_idx;

  lcd_cfg_rom u_cfg_rom (
    .cfg_idx  (w_rom_idx),
    .cfg_byte (w_cfg_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= PWR_WAIT;
      r_cnt        <= '0;
      r_nib_idx    <= 2'd0;
      r_cfg_idx    <= 2'd0;
      r_line       <= 1'b0;
      r_col        <= 4'd0;
      r_init_sel   <= 1'b1;
      r_init_sf_d  <= 4'd0;
      r_init_lcd_e <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_cmd_db     <= 8'h00;
      r_cmd_instr  <= INSTR_CMD;
    end else begin
      r_cnt       <= r_cnt + 1'b1;
      r_cmd_ready <= 1'b0;
      case (r_state)
        PWR_WAIT: begin
          if (r_cnt == L_PWR) begin
            r_state     <= NIB_SETUP;
            r_cnt       <= '0;
            r_nib_idx   <= 2'd0;
            r_init_sf_d <= nib_value(2'd0);
          end
        end

        NIB_SETUP: begin
          if (r_cnt == L_SETUP) begin
            r_state      <= NIB_PULSE;
            r_cnt        <= '0;
            r_init_lcd_e <= 1'b1;
          end
        end

        NIB_PULSE: begin
          if (r_cnt == L_E) begin
            r_state      <= NIB_WAIT;
            r_cnt        <= '0;
            r_init_lcd_e <= 1'b0;
          end
        end

        NIB_WAIT: begin
          if (r_cnt == w_nib_last) begin
            r_cnt <= '0;
            if (r_nib_idx == 2'd3) begin
              // Hand the pins over to the command unit and start configuration
              r_state     <= CFG_ISSUE;
              r_init_sel  <= 1'b0;
              r_init_sf_d <= 4'd0;
              r_cfg_idx   <= 2'd0;
              r_cmd_ready <= 1'b1;
              r_cmd_instr <= INSTR_CMD;
              r_cmd_db    <= w_cfg_byte;
            end else begin
              r_state     <= NIB_SETUP;
              r_nib_idx   <= r_nib_idx + 2'd1;
              r_init_sf_d <= nib_value(r_nib_idx + 2'd1);
            end
          end
        end

        CFG_ISSUE: begin
          r_state <= CFG_WAIT;
          r_cnt   <= '0;
        end

        CFG_WAIT: begin
          if (cmd_done) begin
            r_cnt <= '0;
            if (r_cfg_idx == 2'd3) begin
              r_state <= CLR_WAIT;
            end else begin
              r_state     <= CFG_ISSUE;
              r_cfg_idx   <= r_cfg_idx + 2'd1;
              r_cmd_ready <= 1'b1;
              r_cmd_instr <= INSTR_CMD;
              r_cmd_db    <= w_cfg_byte;
            end
          end
        end

        CLR_WAIT: begin
          if (r_cnt == L_CLR) begin
            r_state     <= ADDR_ISSUE;
            r_cnt       <= '0;
            r_line      <= 1'b0;
            r_col       <= 4'd0;
            r_cmd_ready <= 1'b1;
            r_cmd_instr <= INSTR_CMD;
            r_cmd_db    <= DDRAM_LINE0;
          end
        end

        ADDR_ISSUE: begin
          r_state <= ADDR_WAIT;
          r_cnt   <= '0;
        end

        ADDR_WAIT: begin
          if (cmd_done) begin
            r_state     <= CHR_ISSUE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_cmd_instr <= INSTR_DATA;
            r_cmd_db    <= char_data;
          end
        end

        // col advances here so char_addr already points at the next character
        // while the current one is in flight; a wrap to 0 marks the end of the line.
        CHR_ISSUE: begin
          r_state <= CHR_WAIT;
          r_cnt   <= '0;
          r_col   <= r_col + 4'd1;
        end

        CHR_WAIT: begin
          if (cmd_done) begin
            r_cnt <= '0;
            if (r_col != 4'd0) begin
              r_state     <= CHR_ISSUE;
              r_cmd_ready <= 1'b1;
              r_cmd_instr <= INSTR_DATA;
              r_cmd_db    <= char_data;
            end else if (!r_line) begin
              r_state     <= ADDR_ISSUE;
              r_line      <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_cmd_instr <= INSTR_CMD;
              r_cmd_db    <= DDRAM_LINE1;
            end else begin
              r_state <= FRAME_WAIT;
              r_line  <= 1'b0;
            end
          end
        end

        FRAME_WAIT: begin
          if (r_cnt == L_FRAME) begin
            r_state     <= ADDR_ISSUE;
            r_cnt       <= '0;
            r_line      <= 1'b0;
            r_col       <= 4'd0;
            r_cmd_ready <= 1'b1;
            r_cmd_instr <= INSTR_CMD;
            r_cmd_db    <= DDRAM_LINE0;
          end
        end

        default: begin
          r_state <= PWR_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign init_sel   = r_init_sel;
  assign init_sf_d  = r_init_sf_d;
  assign init_lcd_e = r_init_lcd_e;
  assign cmd_ready  = r_cmd_ready;
  assign cmd_db     = r_cmd_db;
  assign cmd_instr  = r_cmd_instr;
  assign char_addr  = {r_line, r_col};

endmodule
